// File: rtl/axi_prog_loader.sv
// AXI4-Lite write master: packs a little-endian byte stream into words, writes them from
// BASE_ADDR, appends TERM_WORD, then holds cpu_start. Define PROG_LOADER_CHECKSUM_EN for checksum.
module axi_prog_loader #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 128,
  parameter logic [31:0] TERM_WORD = 32'hFFFF_FFFF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_data,
  input  logic                           in_last,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [ADDR_W-1:0]              awaddr,
  output logic                           wvalid,
  input  logic                           wready,
  output logic [31:0]                    wdata,
  input  logic                           bvalid,
  output logic                           bready,
  input  logic [1:0]                     bresp,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
  output logic                           load_done,
  output logic                           cpu_start,
  output logic                           error,
  output logic [31:0]                    checksum
);

  localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StResp,
    StTerm,
    StTermResp,
    StDone,
    StError
  } state_e;

  state_e              state_q;
  logic [1:0]          lane_q;
  logic [31:0]         word_q;
  logic                last_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                in_ready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [31:0]         wdata_q;
  logic [CntW-1:0]     word_count_q;
  logic                load_done_q;
  logic                cpu_start_q;
  logic                error_q;

  logic                byte_acc;
  logic                word_end;
  logic [31:0]         word_nxt;
  logic                aw_hs;
  logic                w_hs;
  logic                both_done;
  logic                b_hs;
  logic [CntW-1:0]     cnt_inc;
  logic [ADDR_W-1:0]   addr_cur;
  logic [ADDR_W-1:0]   addr_term;

  always_comb begin
    byte_acc  = in_valid && in_ready_q;
    word_nxt  = word_q | (32'(in_data) << {lane_q, 3'b000});
    word_end  = byte_acc && ((lane_q == 2'd3) || in_last);
    aw_hs     = awvalid_q && awready;
    w_hs      = wvalid_q && wready;
    // Channels finish independently; a handshake this cycle counts as done.
    both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    b_hs      = bready_q && bvalid;
    cnt_inc   = word_count_q + 1'b1;
    addr_cur  = ADDR_W'(BASE_ADDR) + (ADDR_W'(word_count_q) << 2);
    addr_term = ADDR_W'(BASE_ADDR) + (ADDR_W'(cnt_inc) << 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lane_q       <= 2'd0;
      word_q       <= '0;
      last_q       <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
      cpu_start_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q    <= StCollect;
            in_ready_q <= 1'b1;
            lane_q     <= 2'd0;
            word_q     <= '0;
            last_q     <= 1'b0;
          end
        end
        StCollect: begin
          if (byte_acc) begin
            lane_q <= lane_q + 2'd1;
            word_q <= word_nxt;
            if (word_end) begin
              state_q    <= StWrite;
              in_ready_q <= 1'b0;
              last_q     <= in_last;
              awvalid_q  <= 1'b1;
              wvalid_q   <= 1'b1;
              awaddr_q   <= addr_cur;
              wdata_q    <= word_nxt;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
            end
          end
        end
        StWrite, StTerm: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (both_done) begin
            state_q  <= (state_q == StWrite) ? StResp : StTermResp;
            bready_q <= 1'b1;
          end
        end
        StResp: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            if (bresp != 2'b00) begin
              state_q <= StError;
              error_q <= 1'b1;
            end else begin
              word_count_q <= cnt_inc;
              if (last_q) begin
                state_q   <= StTerm;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                awaddr_q  <= addr_term;
                wdata_q   <= TERM_WORD;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
              end else if (cnt_inc == CntW'(MAX_WORDS)) begin
                state_q <= StError;
                error_q <= 1'b1;
              end else begin
                state_q    <= StCollect;
                in_ready_q <= 1'b1;
                lane_q     <= 2'd0;
                word_q     <= '0;
              end
            end
          end
        end
        StTermResp: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            if (bresp == 2'b00) begin
              state_q     <= StDone;
              load_done_q <= 1'b1;
              cpu_start_q <= 1'b1;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end
        StDone, StError: begin
        end
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;
  logic        img_ok;

  assign img_ok = (state_q == StResp) && b_hs && (bresp == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (img_ok) begin
      checksum_q <= checksum_q + wdata_q;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign in_ready   = in_ready_q;
  assign awvalid    = awvalid_q;
  assign awaddr     = awaddr_q;
  assign wvalid     = wvalid_q;
  assign wdata      = wdata_q;
  assign bready     = bready_q;
  assign word_count = word_count_q;
  assign load_done  = load_done_q;
  assign cpu_start  = cpu_start_q;
  assign error      = error_q;

endmodule

// File: doc/axi_prog_loader.md
Name: axi_prog_loader

Overview:
- AXI4-Lite write master that loads a program image into the BRAM controller, then releases the CPU control unit.
- Replaces bench-side word packing and pulse-timed AW/W/B sequencing with real ready/valid handshaking.
- Consumes a little-endian byte stream (ROM, UART or bench), packs it into words, writes them to consecutive addresses from BASE_ADDR, appends a terminator word, then holds cpu_start high.

Parameters:
- ADDR_W, 20, AXI address width.
- BASE_ADDR, 0, byte address of the first word; must be 4-aligned.
- MAX_WORDS, 128, maximum image words, terminator excluded.
- TERM_WORD, 32'hFFFFFFFF, word written immediately after the last image word.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- go  in  1  start a load; sampled only in IDLE.
- in_valid  in  1  byte stream valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_data  in  8  byte data.
- in_last  in  1  marks the final byte of the image.
- awvalid/awready/awaddr  out/in/out  1/1/ADDR_W  AXI write-address channel.
- wvalid/wready/wdata  out/in/out  1/1/32  AXI write-data channel; wstrb is fixed 4'b1111 outside this block.
- bvalid/bready/bresp  in/out/in  1/1/2  AXI write-response channel.
- word_count  out  $clog2(MAX_WORDS+1)  image words written and acknowledged.
- load_done  out  1  level; terminator acknowledged.
- cpu_start  out  1  level; drives control_unit start.
- error  out  1  sticky fault flag.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs 0 on the cycle after rst is sampled high: valids, bready, in_ready, load_done, cpu_start, error, word_count, checksum. State = IDLE.
- Reset mid-transaction aborts immediately; valids drop without completion. The BRAM controller shares rst, so this is legal.
- States: IDLE, COLLECT, WRITE, RESP, TERM, TERM_RESP, DONE, ERROR.
- IDLE: go=1 -> COLLECT; byte lane and word index cleared.
- COLLECT: in_ready=1.
  - Each accepted byte is placed in lane k (byte k at bits 8k+7:8k); k increments.
  - Word complete when lane 3 is accepted, or when in_last is accepted. Unfilled lanes are zero.
  - Word complete -> WRITE. in_ready=0 on the following cycle.
- WRITE: awvalid and wvalid rise in the same cycle.
  - awaddr = BASE_ADDR + 4*index, modulo 2^ADDR_W.
  - Each valid holds, with stable payload, until its own ready is seen; the two channels complete independently, in either order or simultaneously.
  - When both have completed -> RESP.
- RESP: bready=1 until bvalid. word_count increments on the response.
  - bresp != 2'b00 -> ERROR.
  - Else if the word carried in_last -> TERM.
  - Else if word_count == MAX_WORDS -> ERROR (overflow).
  - Else -> COLLECT.
- TERM: same handshake as WRITE with TERM_WORD at the next address -> TERM_RESP.
- TERM_RESP: bready=1 until bvalid. bresp OK -> DONE; otherwise ERROR. word_count does not count the terminator.
- DONE: load_done=1, cpu_start=1, held until rst. go ignored.
- ERROR: error=1 and cpu_start=0, held until rst. No further AXI traffic.
- in_last on a byte that exactly fills MAX_WORDS words is legal and must not flag overflow.
- go or bytes arriving while not ready are ignored; no buffering.
- Minimum cost per word: 4 byte cycles + 1 AW/W cycle + 1 B cycle.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: checksum = 32-bit wrapping sum of all image words as written, zero-padded words included, terminator excluded. Updated at each OKAY response; valid once load_done=1.
- Not defined: checksum tied to 0. No adder is generated.

Test Plan:
- Nominal: 8 bytes 01..08, in_last on 08, BASE_ADDR=0, BRAM always ready.
  - Writes: 0x04030201 @0x0, 0x08070605 @0x4, 0xFFFFFFFF @0x8.
  - word_count=2, load_done=cpu_start=1, checksum=0x0C0A0806 when enabled.
- Partial word: 5 bytes AA BB CC DD EE, in_last on EE.
  - Second word written = 0x000000EE; terminator @0x8.
- Backpressure: awready delayed 3 cycles, wready delayed 1 cycle; repeat with the order reversed.
  - Payloads stay stable while valid; each channel completes exactly once; AXI data matches the nominal case.
- Error response: bresp=2'b10 on the second word.
  - error=1, cpu_start=0, no TERM write, word_count=1.
- Overflow: MAX_WORDS=2, 12 bytes with in_last on byte 12.
  - Error after the second response. Same test with in_last on byte 8 -> DONE, no error.
- Reset mid-WRITE: rst=1 while awvalid=1.
  - Next cycle all outputs 0. A new go then loads correctly from BASE_ADDR.
